// File: rtl/window_pkg.sv
// Shared types and constants for the window matcher: geometry, SAD/position widths, FSM states.
package window_pkg;

  localparam int unsigned WIN_DIM    = 16;
  localparam int unsigned SEARCH_DIM = 80;
  localparam int unsigned POS_MAX    = SEARCH_DIM - WIN_DIM;
  localparam int unsigned ROW_W      = $clog2(WIN_DIM);

  typedef logic [WIN_DIM-1:0][7:0]              row_t;
  typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][7:0] window_t;
  typedef logic [15:0]                          sad_t;
  typedef logic [6:0]                           pos_t;

  localparam pos_t POS_LAST = pos_t'(POS_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StWaitWin,
    StAccum,
    StReport
  } state_e;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/row_sad.sv
// Combinational sum of absolute byte differences across one 16-byte window row.
module row_sad
  import window_pkg::*;
(
  input  row_t        i_row_a,
  input  row_t        i_row_b,
  output logic [11:0] o_sad
);

  // 16 * 255 = 4080 fits in 12 bits.
  always_comb begin
    o_sad = '0;
    for (int unsigned i = 0; i < WIN_DIM; i++) begin
      o_sad = o_sad + 12'(abs_diff(i_row_a[i], i_row_b[i]));
    end
  end

endmodule

// File: rtl/window_matcher.sv
// Raster-order SAD template search over 65x65 window offsets, one window row per cycle.
// Define WINDOW_MATCHER_EARLY_ABORT_EN to end a window as soon as it cannot beat the best.
module window_matcher
  import window_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_start,
  input  window_t i_template_data,
  input  window_t i_window_data,
  input  logic    i_window_ready,
  input  logic    i_src_done,
  output logic    o_receive,
  output logic    o_busy,
  output logic    o_result_valid,
  output sad_t    o_best_sad,
  output pos_t    o_best_row,
  output pos_t    o_best_col
);

  state_e           r_state;
  window_t          r_template;
  window_t          r_window;
  logic [ROW_W-1:0] r_row;
  sad_t             r_partial;
  sad_t             r_best_sad;
  pos_t             r_best_row;
  pos_t             r_best_col;
  pos_t             r_pos_row;
  pos_t             r_pos_col;
  logic             r_last;
  logic             r_result_valid;

  logic [11:0] w_row_sad;
  sad_t        w_partial_nxt;
  logic        w_accum_end;

  row_sad u_row_sad (
    .i_row_a (r_template[r_row]),
    .i_row_b (r_window[r_row]),
    .o_sad   (w_row_sad)
  );

  // Cannot overflow: the largest possible total is 65280.
  assign w_partial_nxt = r_partial + sad_t'(w_row_sad);

`ifdef WINDOW_MATCHER_EARLY_ABORT_EN
  assign w_accum_end = (r_row == ROW_W'(WIN_DIM - 1)) || (w_partial_nxt >= r_best_sad);
`else
  assign w_accum_end = (r_row == ROW_W'(WIN_DIM - 1));
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_row          <= '0;
      r_partial      <= '0;
      r_best_sad     <= '1;
      r_best_row     <= '0;
      r_best_col     <= '0;
      r_pos_row      <= '0;
      r_pos_col      <= '0;
      r_last         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_template <= i_template_data;
            r_pos_row  <= '0;
            r_pos_col  <= '0;
            r_best_sad <= '1;
            r_partial  <= '0;
            r_state    <= StWaitWin;
          end
        end
        StWaitWin: begin
          if (i_window_ready) begin
            r_window  <= i_window_data;
            r_last    <= i_src_done || ((r_pos_row == POS_LAST) && (r_pos_col == POS_LAST));
            r_row     <= '0;
            r_partial <= '0;
            r_state   <= StAccum;
          end
        end
        StAccum: begin
          if (w_accum_end) begin
            // Strict less-than keeps the earliest window on ties.
            if (w_partial_nxt < r_best_sad) begin
              r_best_sad <= w_partial_nxt;
              r_best_row <= r_pos_row;
              r_best_col <= r_pos_col;
            end
            if (r_pos_col == POS_LAST) begin
              r_pos_col <= '0;
              r_pos_row <= r_pos_row + 7'd1;
            end else begin
              r_pos_col <= r_pos_col + 7'd1;
            end
            r_partial <= '0;
            r_row     <= '0;
            if (r_last) begin
              r_state        <= StReport;
              r_result_valid <= 1'b1;
            end else begin
              r_state <= StWaitWin;
            end
          end else begin
            r_partial <= w_partial_nxt;
            r_row     <= r_row + 1'b1;
          end
        end
        StReport: r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign o_receive      = (r_state == StWaitWin) && i_window_ready;
  assign o_busy         = (r_state != StIdle);
  assign o_result_valid = r_result_valid;
  assign o_best_sad     = r_best_sad;
  assign o_best_row     = r_best_row;
  assign o_best_col     = r_best_col;

endmodule

// File: tb/tb_window_matcher.sv
// Directed self-checking bench for window_matcher; a small SAD model covers the held-input run.
module tb_window_matcher;
  import window_pkg::*;

`ifdef WINDOW_MATCHER_EARLY_ABORT_EN
  localparam int MinGap = 2;
`else
  localparam int MinGap = 17;
`endif

  logic    i_clk = 1'b0;
  logic    i_rst;
  logic    i_start;
  window_t i_template_data;
  window_t i_window_data;
  logic    i_window_ready;
  logic    i_src_done;
  logic    o_receive;
  logic    o_busy;
  logic    o_result_valid;
  sad_t    o_best_sad;
  pos_t    o_best_row;
  pos_t    o_best_col;

  int n_checks = 0;
  int n_pass   = 0;

  window_matcher dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_template_data (i_template_data),
    .i_window_data   (i_window_data),
    .i_window_ready  (i_window_ready),
    .i_src_done      (i_src_done),
    .o_receive       (o_receive),
    .o_busy          (o_busy),
    .o_result_valid  (o_result_valid),
    .o_best_sad      (o_best_sad),
    .o_best_row      (o_best_row),
    .o_best_col      (o_best_col)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic window_t mk_tmpl(input int mode);
    window_t t;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (mode)
          1:       t[r][c] = 8'h10;
          5:       t[r][c] = 8'(r * 37 + c * 11 + 3);
          default: t[r][c] = 8'h00;
        endcase
      end
    end
    return t;
  endfunction

  function automatic window_t mk_win(input int mode, input int pr, input int pc);
    window_t w;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (mode)
          0: w[r][c] = (pr == 3 && pc == 5) ? 8'h01 : 8'h00;
          1: w[r][c] = (pr == 10 && pc == 20) ? 8'h10 : 8'h11;
          2: w[r][c] = 8'hFF;
          3: begin
            if ((pr == 0 && pc == 2 && r == 7 && c == 3) || (pr == 1 && pc == 0 && r == 12 && c == 9))
              w[r][c] = 8'h05;
            else if ((pr == 0 && pc == 2) || (pr == 1 && pc == 0))
              w[r][c] = 8'h00;
            else
              w[r][c] = 8'h01;
          end
          default: begin
            if (pc == 6) w[r][c] = 8'(r * 37 + c * 11 + 3 + (c % 3) - 1);
            else         w[r][c] = 8'(r * 53 + c * 29 + pr * 7 + pc * 13);
          end
        endcase
      end
    end
    return w;
  endfunction

  function automatic int sad_of(input window_t t, input window_t w);
    int s = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (t[r][c] > w[r][c]) s += int'(t[r][c]) - int'(w[r][c]);
        else                   s += int'(w[r][c]) - int'(t[r][c]);
      end
    end
    return s;
  endfunction

  // Runs one search; exp_sad < 0 means expectations come from the SAD model.
  task automatic run_search(input string tag, input int mode, input int nwin, input bit hold,
                            input int exp_sad, input int exp_row, input int exp_col,
                            output int lat, output int min_gap);
    window_t tmpl, win;
    int idx = 0, cyc = 0, rv_cnt = 0, last_cap = -1, rv_cyc = 0;
    int best = 32'hFFFF, brow = 0, bcol = 0, s;
    bit done = 0;
    min_gap = 1000;
    tmpl = mk_tmpl(mode);
    win  = mk_win(mode, 0, 0);
    i_template_data = tmpl;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = hold;
    while (!done && cyc < nwin * 20 + 40) begin
      if (idx < nwin) begin
        win = mk_win(mode, idx / 65, idx % 65);
        i_window_data  = win;
        i_window_ready = 1'b1;
        i_src_done     = (idx == nwin - 1);
      end else begin
        i_window_ready = hold;
        i_src_done     = 1'b0;
        i_start        = 1'b0;
      end
      #1;
      if (o_receive) begin
        s = sad_of(tmpl, win);
        if (s < best) begin
          best = s; brow = idx / 65; bcol = idx % 65;
        end
        if (last_cap >= 0 && cyc - last_cap < min_gap) min_gap = cyc - last_cap;
        last_cap = cyc;
        idx++;
      end
      if (o_result_valid) begin
        rv_cnt++; rv_cyc = cyc; done = 1;
      end
      @(negedge i_clk);
      cyc++;
    end
    check({tag, "_finished"}, 32'(done), 1);
    i_window_ready = 1'b0;
    i_start        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (o_result_valid) rv_cnt++;
      @(negedge i_clk);
    end
    lat = rv_cyc - last_cap;
    if (exp_sad < 0) begin
      exp_sad = best; exp_row = brow; exp_col = bcol;
    end
    check({tag, "_windows"},  32'(idx), 32'(nwin));
    check({tag, "_rv_count"}, 32'(rv_cnt), 1);
    check({tag, "_busy"},     32'(o_busy), 0);
    check({tag, "_best_sad"}, 32'(o_best_sad), 32'(exp_sad));
    check({tag, "_best_row"}, 32'(o_best_row), 32'(exp_row));
    check({tag, "_best_col"}, 32'(o_best_col), 32'(exp_col));
  endtask

  task automatic reset_mid_accum();
    int rv_cnt = 0, w = 0;
    i_template_data = mk_tmpl(5);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start        = 1'b0;
    i_window_data  = mk_win(5, 0, 0);
    i_window_ready = 1'b1;
    #1;
    while (!o_receive && w < 10) begin
      @(negedge i_clk); #1; w++;
    end
    check("rst_capture", 32'(o_receive), 1);
    @(negedge i_clk);
    i_window_ready = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      #1;
      if (o_result_valid) rv_cnt++;
      @(negedge i_clk);
    end
    check("rst_busy_before", 32'(o_busy), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_busy",     32'(o_busy), 0);
    check("rst_best_sad", 32'(o_best_sad), 32'hFFFF);
    check("rst_best_row", 32'(o_best_row), 0);
    check("rst_best_col", 32'(o_best_col), 0);
    for (int k = 0; k < 20; k++) begin
      if (o_result_valid) rv_cnt++;
      @(negedge i_clk); #1;
    end
    check("rst_no_result", 32'(rv_cnt), 0);
  endtask

  initial begin
    int lat, gap;
    i_rst = 1'b1; i_start = 1'b0; i_window_ready = 1'b0; i_src_done = 1'b0;
    i_template_data = '0; i_window_data = '0;
    repeat (2) @(negedge i_clk);
    i_window_ready = 1'b1;
    #1;
    check("reset_receive",  32'(o_receive), 0);
    check("reset_busy",     32'(o_busy), 0);
    check("reset_valid",    32'(o_result_valid), 0);
    check("reset_best_sad", 32'(o_best_sad), 32'hFFFF);
    check("reset_best_row", 32'(o_best_row), 0);
    check("reset_best_col", 32'(o_best_col), 0);
    @(negedge i_clk);
    i_rst = 1'b0; i_window_ready = 1'b0;
    @(negedge i_clk);

    run_search("zero_tmpl", 0, 203, 1'b0, 0, 0, 0, lat, gap);
    run_search("exact_10_20", 1, 681, 1'b0, 0, 10, 20, lat, gap);
    reset_mid_accum();
    run_search("all_ff", 2, 1, 1'b0, 65280, 0, 0, lat, gap);
    check("report_latency", 32'(lat), 17);
    run_search("tie", 3, 67, 1'b0, 5, 0, 2, lat, gap);
    run_search("held_inputs", 5, 12, 1'b1, -1, 0, 0, lat, gap);
    check("held_min_gap_ok", 32'(gap >= MinGap), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
